serial_adder: RTL and testbench

- Bit-serial multi-bit adder built around one instance of the team's existing single-bit full adder `fa` (ports A, B, Cin, S, Cout).
- Loads two WIDTH-bit operands on a start pulse and feeds them LSB-first through `fa`, one bit per clock, with the carry held in a flip-flop between bits.
- Presents the sum and carry-out with a one-cycle done strobe.
- Serves as the sequential datapath stage that consumes the `fa` cell; it is the reference serial-arithmetic block for the fabric.

---
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a flop.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.

module fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fa u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_c)
  );

  // DONE accepts start exactly like IDLE so held start gives back-to-back adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= SHIFT;
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sr <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit, carry is the carry into the MSB and fa_c the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && cnt == LAST) begin
      ovf <= carry ^ fa_c;
    end
  end
`endif

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign sum  = sum_sr;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); checks ovf when
// SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One start pulse, then count busy cycles up to the done strobe and check results.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input string tag);
    int  nbusy = 0;
    bit  seen  = 0;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) nbusy++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x on ovf expectation");
`endif
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_sum_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int ndone;
    int pos[$];
    logic [W-1:0] cap_sum;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    do_add(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "add_cin");

    // Start pulsed during the 3rd busy cycle must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; cap_sum = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        ndone++;
        cap_sum = sum;
        chk("ignore_cout", 32'(cout), 32'd0);
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_sum", 32'(cap_sum), 32'h30);

    // Reset in the 4th busy cycle aborts at once.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

    // Held start: one done every W+1 cycles.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        pos.push_back(i);
        chk("b2b_sum", 32'(sum), 32'h10);
        chk("b2b_cout", 32'(cout), 32'd0);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(pos.size()), 32'd3);
    if (pos.size() == 3) begin
      chk("b2b_first", 32'(pos[0]), 32'd9);
      chk("b2b_gap1", 32'(pos[1] - pos[0]), 32'(W + 1));
      chk("b2b_gap2", 32'(pos[2] - pos[1]), 32'(W + 1));
    end
    repeat (12) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos");
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ovf_none");
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
